// File: rtl/xpb_pkg.sv
// Shared types and helpers for the xpb table generator and related reduction blocks.
package xpb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GEN   = 2'd1,
        READY = 2'd2
    } state_t;

    localparam int DEF_IDX_W     = 5;
    localparam int DEF_DATA_W    = 1024;
    localparam int DEF_NUM_PORTS = 2;

    function automatic int depth_of(input int idx_w);
        return 1 << idx_w;
    endfunction

    // Low bit of port p's field in a packed multi-port bus of w-bit fields.
    function automatic int port_lo(input int p, input int w);
        return p * w;
    endfunction

endpackage

// File: rtl/xpb_mod_add.sv
// Combinational modular adder: r = (a + b) mod m, valid when a < m and b < m.
module xpb_mod_add #(
    parameter int DATA_W = 1024
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] m,
    output logic [DATA_W-1:0] r
);

    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] diff;

    assign sum  = {1'b0, a} + {1'b0, b};
    // The true difference is below m, so the carry bit can be dropped.
    assign diff = sum[DATA_W-1:0] - m;
    assign r    = (sum >= {1'b0, m}) ? diff : sum[DATA_W-1:0];

endmodule

// File: rtl/xpb_table_gen.sv
// Builds table[j] = (j*base) mod modulus by repeated modular addition, then serves
// registered lookups on NUM_PORTS independent read ports.
module xpb_table_gen
    import xpb_pkg::*;
#(
    parameter int IDX_W     = DEF_IDX_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int NUM_PORTS = DEF_NUM_PORTS
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [DATA_W-1:0]             base,
    input  logic [DATA_W-1:0]             modulus,
    output logic                          busy,
    output logic                          ready,
    output logic                          err,
    input  logic [NUM_PORTS-1:0]          rd_en,
    input  logic [NUM_PORTS*IDX_W-1:0]    rd_idx,
    output logic [NUM_PORTS*DATA_W-1:0]   rd_data,
    output logic [NUM_PORTS-1:0]          rd_valid
);

    localparam int DEPTH = depth_of(IDX_W);

    state_t              state_reg;
    logic [DATA_W-1:0]   base_reg;
    logic [DATA_W-1:0]   mod_reg;
    logic [DATA_W-1:0]   acc_reg;
    logic [DATA_W-1:0]   acc_next;
    logic [IDX_W-1:0]    cnt_reg;
    logic                busy_reg;
    logic                ready_reg;
    logic                err_reg;

    logic [DATA_W-1:0]   table_mem [DEPTH];

    xpb_mod_add #(.DATA_W(DATA_W)) u_add (
        .a (acc_reg),
        .b (base_reg),
        .m (mod_reg),
        .r (acc_next)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            base_reg  <= '0;
            mod_reg   <= '0;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            busy_reg  <= 1'b0;
            ready_reg <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE, READY: begin
                    if (start) begin
                        base_reg  <= base;
                        mod_reg   <= modulus;
                        acc_reg   <= '0;
                        cnt_reg   <= '0;
                        ready_reg <= 1'b0;
                        // base >= modulus also covers modulus == 0
                        if (base >= modulus) begin
                            err_reg   <= 1'b1;
                            busy_reg  <= 1'b0;
                            state_reg <= IDLE;
                        end else begin
                            err_reg   <= 1'b0;
                            busy_reg  <= 1'b1;
                            state_reg <= GEN;
                        end
                    end
                end
                GEN: begin
                    acc_reg <= acc_next;
                    cnt_reg <= cnt_reg + 1'b1;
                    if (cnt_reg == IDX_W'(DEPTH - 1)) begin
                        busy_reg  <= 1'b0;
                        ready_reg <= 1'b1;
                        state_reg <= READY;
                    end
                end
                default: begin
                    busy_reg  <= 1'b0;
                    ready_reg <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Storage carries no reset; it is only meaningful once ready is high.
    always_ff @(posedge clk) begin
        if (state_reg == GEN) begin
            table_mem[cnt_reg] <= acc_reg;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            logic [IDX_W-1:0]  idx;
            logic [DATA_W-1:0] data_reg;
            logic              valid_reg;

            assign idx = rd_idx[port_lo(gi, IDX_W) +: IDX_W];

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    data_reg  <= '0;
                    valid_reg <= 1'b0;
                end else if (ready_reg && rd_en[gi]) begin
                    data_reg  <= table_mem[idx];
                    valid_reg <= 1'b1;
                end else begin
                    valid_reg <= 1'b0;
                end
            end

            assign rd_data[port_lo(gi, DATA_W) +: DATA_W] = data_reg;
            assign rd_valid[gi] = valid_reg;
        end
    endgenerate

    assign busy  = busy_reg;
    assign ready = ready_reg;
    assign err   = err_reg;

endmodule

// File: tb/tb_xpb_table_gen.sv
// Bench for xpb_table_gen: a small 3x16 instance for directed/corner cases and a
// default 1024-bit instance for random operands against (j*base) mod modulus.
module tb_xpb_table_gen;

    localparam int SI = 3;
    localparam int SD = 16;
    localparam int LI = 5;
    localparam int LD = 1024;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic              s_start;
    logic [SD-1:0]     s_base, s_mod;
    logic              s_busy, s_ready, s_err;
    logic [1:0]        s_en;
    logic [2*SI-1:0]   s_idx;
    logic [2*SD-1:0]   s_data;
    logic [1:0]        s_valid;

    logic              l_start;
    logic [LD-1:0]     l_base, l_mod;
    logic              l_busy, l_ready, l_err;
    logic [1:0]        l_en;
    logic [2*LI-1:0]   l_idx;
    logic [2*LD-1:0]   l_data;
    logic [1:0]        l_valid;

    xpb_table_gen #(.IDX_W(SI), .DATA_W(SD), .NUM_PORTS(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .start(s_start), .base(s_base), .modulus(s_mod),
        .busy(s_busy), .ready(s_ready), .err(s_err),
        .rd_en(s_en), .rd_idx(s_idx), .rd_data(s_data), .rd_valid(s_valid)
    );

    xpb_table_gen dut_l (
        .clk(clk), .rst_n(rst_n), .start(l_start), .base(l_base), .modulus(l_mod),
        .busy(l_busy), .ready(l_ready), .err(l_err),
        .rd_en(l_en), .rd_idx(l_idx), .rd_data(l_data), .rd_valid(l_valid)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [1:0]    en;
        logic [SI-1:0] i0;
        logic [SI-1:0] i1;
        logic [1:0]    ev;
        logic [SD-1:0] e0;
        logic [SD-1:0] e1;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [LD-1:0] act, input logic [LD-1:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act[127:0], want[127:0]);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic int sref(input int j, input int b, input int m);
        return (j * b) % m;
    endfunction

    function automatic logic [LD-1:0] lref(input int j, input logic [LD-1:0] b, input logic [LD-1:0] m);
        logic [LD+7:0] p;
        logic [LD+7:0] r;
        p = (LD + 8)'(j) * {8'd0, b};
        r = p % {8'd0, m};
        return r[LD-1:0];
    endfunction

    task automatic wait_small(output int cyc);
        cyc = 0;
        while (!s_ready && cyc < 40) begin
            tick;
            cyc++;
        end
    endtask

    task automatic wait_large(output int cyc);
        cyc = 0;
        while (!l_ready && cyc < 80) begin
            tick;
            cyc++;
        end
    endtask

    task automatic read_all_small(input string tag, input int b, input int m);
        for (int j = 0; j < 8; j++) begin
            s_en  = 2'b11;
            s_idx = {SI'(7 - j), SI'(j)};
            tick;
            $display("[%s] read p0 idx %0d -> %0d, p1 idx %0d -> %0d", tag, j, s_data[SD-1:0], 7 - j, s_data[2*SD-1:SD]);
            chk($sformatf("%s_valid_%0d", tag, j), s_valid, 2'b11);
            chk($sformatf("%s_p0_%0d", tag, j), s_data[SD-1:0], SD'(sref(j, b, m)));
            chk($sformatf("%s_p1_%0d", tag, j), s_data[2*SD-1:SD], SD'(sref(7 - j, b, m)));
        end
        s_en = 2'b00;
    endtask

    task automatic start_small(input int b, input int m);
        s_base  = SD'(b);
        s_mod   = SD'(m);
        s_start = 1'b1;
        tick;
        s_start = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int cyc;
        logic [SD-1:0] hold0, hold1;
        logic [LD-1:0] b, m, rnd;

        vecs[0] = '{2'b11, 3'd0, 3'd7, 2'b11, 16'd0,  16'd9};
        vecs[1] = '{2'b11, 3'd1, 3'd6, 2'b11, 16'd5,  16'd4};
        vecs[2] = '{2'b11, 3'd2, 3'd5, 2'b11, 16'd10, 16'd12};
        vecs[3] = '{2'b11, 3'd3, 3'd4, 2'b11, 16'd2,  16'd7};
        vecs[4] = '{2'b01, 3'd4, 3'd0, 2'b01, 16'd7,  16'd7};
        vecs[5] = '{2'b10, 3'd0, 3'd5, 2'b10, 16'd7,  16'd12};
        vecs[6] = '{2'b00, 3'd0, 3'd0, 2'b00, 16'd7,  16'd12};
        vecs[7] = '{2'b11, 3'd6, 3'd6, 2'b11, 16'd4,  16'd4};
        vecs[8] = '{2'b01, 3'd1, 3'd0, 2'b01, 16'd5,  16'd4};
        vecs[9] = '{2'b11, 3'd7, 3'd7, 2'b11, 16'd9,  16'd9};

        rst_n = 1'b0;
        s_start = 1'b0; s_base = '0; s_mod = '0; s_en = '0; s_idx = '0;
        l_start = 1'b0; l_base = '0; l_mod = '0; l_en = '0; l_idx = '0;
        tick;
        tick;
        $display("reset: busy=%0b ready=%0b err=%0b valid=%b data=%h", s_busy, s_ready, s_err, s_valid, s_data);
        chk("rst_busy", s_busy, 1'b0);
        chk("rst_ready", s_ready, 1'b0);
        chk("rst_err", s_err, 1'b0);
        chk("rst_valid", s_valid, 2'b00);
        chk("rst_data", s_data, '0);
        chk("rst_l_ready", l_ready, 1'b0);
        rst_n = 1'b1;
        tick;

        // Generation 5/13 and latency of ready
        start_small(5, 13);
        $display("gen 5/13: busy at T+1 = %0b", s_busy);
        chk("gen_busy_t1", s_busy, 1'b1);
        chk("gen_ready_t1", s_ready, 1'b0);
        wait_small(cyc);
        $display("gen 5/13: ready after %0d cycles", cyc);
        chk("gen_cycles", cyc, 8);
        chk("gen_busy_done", s_busy, 1'b0);

        for (int v = 0; v < 10; v++) begin
            s_en  = vecs[v].en;
            s_idx = {vecs[v].i1, vecs[v].i0};
            tick;
            $display("vec %0d: en=%b idx=%0d/%0d -> valid=%b d0=%0d d1=%0d", v, vecs[v].en, vecs[v].i0, vecs[v].i1, s_valid, s_data[SD-1:0], s_data[2*SD-1:SD]);
            chk($sformatf("vec%0d_valid", v), s_valid, vecs[v].ev);
            chk($sformatf("vec%0d_d0", v), s_data[SD-1:0], vecs[v].e0);
            chk($sformatf("vec%0d_d1", v), s_data[2*SD-1:SD], vecs[v].e1);
        end
        s_en = 2'b00;

        // Start in READY with a same-cycle read: old table answers, ready drops at T+1
        s_en  = 2'b01;
        s_idx = {3'd0, 3'd2};
        start_small(3, 7);
        s_en = 2'b00;
        $display("ready-restart: valid=%b d0=%0d ready=%0b busy=%0b", s_valid, s_data[SD-1:0], s_ready, s_busy);
        chk("rr_valid", s_valid, 2'b01);
        chk("rr_old_data", s_data[SD-1:0], 16'd10);
        chk("rr_ready_drop", s_ready, 1'b0);
        chk("rr_busy", s_busy, 1'b1);
        wait_small(cyc);
        chk("rr_cycles", cyc, 8);
        read_all_small("t37a", 3, 7);

        // Error path: base == modulus
        start_small(13, 13);
        $display("err: err=%0b busy=%0b ready=%0b", s_err, s_busy, s_ready);
        chk("err_set", s_err, 1'b1);
        chk("err_busy", s_busy, 1'b0);
        chk("err_ready", s_ready, 1'b0);
        s_en = 2'b11;
        tick;
        s_en = 2'b00;
        chk("err_no_valid", s_valid, 2'b00);
        tick;
        chk("err_sticky", s_err, 1'b1);
        start_small(3, 7);
        chk("err_cleared", s_err, 1'b0);
        chk("err_restart_busy", s_busy, 1'b1);

        // Reset in the middle of generation
        tick;
        tick;
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        $display("mid-gen reset: busy=%0b ready=%0b err=%0b valid=%b data=%h", s_busy, s_ready, s_err, s_valid, s_data);
        chk("mrst_busy", s_busy, 1'b0);
        chk("mrst_ready", s_ready, 1'b0);
        chk("mrst_data", s_data, '0);
        for (int k = 0; k < 12; k++) tick;
        chk("mrst_ready_stays", s_ready, 1'b0);
        start_small(3, 7);
        wait_small(cyc);
        chk("mrst_cycles", cyc, 8);
        read_all_small("t37b", 3, 7);

        // start during GEN is ignored
        start_small(5, 13);
        tick;
        start_small(3, 7);
        wait_small(cyc);
        $display("gen with ignored start: ready after %0d more cycles", cyc);
        chk("ign_cycles", cyc, 6);
        read_all_small("t513", 5, 13);

        // Random reads on the 5/13 table; last read_all left p0=idx7, p1=idx0
        hold0 = SD'(sref(7, 5, 13));
        hold1 = SD'(sref(0, 5, 13));
        for (int k = 0; k < 40; k++) begin
            logic [1:0] en;
            logic [SI-1:0] i0, i1;
            en = 2'($urandom_range(0, 3));
            i0 = SI'($urandom_range(0, 7));
            i1 = SI'($urandom_range(0, 7));
            s_en  = en;
            s_idx = {i1, i0};
            if (en[0]) hold0 = SD'(sref(int'(i0), 5, 13));
            if (en[1]) hold1 = SD'(sref(int'(i1), 5, 13));
            tick;
            $display("rand %0d: en=%b idx=%0d/%0d -> valid=%b d0=%0d d1=%0d", k, en, i0, i1, s_valid, s_data[SD-1:0], s_data[2*SD-1:SD]);
            chk($sformatf("rand%0d_valid", k), s_valid, en);
            chk($sformatf("rand%0d_d0", k), s_data[SD-1:0], hold0);
            chk($sformatf("rand%0d_d1", k), s_data[2*SD-1:SD], hold1);
        end
        s_en = 2'b00;

        // Full-width random operands on the default instance
        for (int t = 0; t < 3; t++) begin
            for (int w = 0; w < LD / 32; w++) begin
                m[w*32 +: 32]   = $urandom;
                rnd[w*32 +: 32] = $urandom;
            end
            if (t == 0) m[LD-1] = 1'b1;
            if (m == '0) m = 1;
            b = rnd % m;
            l_base  = b;
            l_mod   = m;
            l_start = 1'b1;
            tick;
            l_start = 1'b0;
            chk($sformatf("l%0d_busy", t), l_busy, 1'b1);
            chk($sformatf("l%0d_err", t), l_err, 1'b0);
            wait_large(cyc);
            $display("large trial %0d: ready after %0d cycles", t, cyc);
            chk($sformatf("l%0d_cycles", t), cyc, 32);
            for (int j = 0; j < 32; j++) begin
                l_en  = 2'b11;
                l_idx = {LI'(31 - j), LI'(j)};
                tick;
                $display("large trial %0d idx %0d/%0d: valid=%b", t, j, 31 - j, l_valid);
                chk($sformatf("l%0d_valid_%0d", t, j), l_valid, 2'b11);
                chk($sformatf("l%0d_p0_%0d", t, j), l_data[LD-1:0], lref(j, b, m));
                chk($sformatf("l%0d_p1_%0d", t, j), l_data[2*LD-1:LD], lref(31 - j, b, m));
            end
            l_en = 2'b00;
            tick;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/xpb_table_gen.md
# xpb_table_gen

Runtime-generated, multi-port successor to the fixed xpb lookup ROMs used by the modular squaring datapath. Instead of hard-coded constants, it computes the table entry[j] = (j·base) mod modulus for j = 0..2^IDX_W−1 by iterated modular addition after a start pulse. It stores the entries internally and then serves registered lookups on NUM_PORTS independent read ports. This lets the reduction stage switch modulus or base without resynthesis.

## Interface
- IDX_W, 5, index width; table depth = 2^IDX_W
- DATA_W, 1024, entry width
- NUM_PORTS, 2, number of independent read ports
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  begin generation; accepted only in IDLE or READY
- base  in  DATA_W  multiplier constant, sampled on accepted start
- modulus  in  DATA_W  modulus, sampled on accepted start
- busy  out  1  high while generating
- ready  out  1  high when table valid and reads are served
- err  out  1  sticky until next accepted start; set if base ≥ modulus (includes modulus = 0)
- rd_en  in  NUM_PORTS  per-port read request
- rd_idx  in  NUM_PORTS·IDX_W  per-port index, port p at bits [p·IDX_W +: IDX_W]
- rd_data  out  NUM_PORTS·DATA_W  per-port entry, port p at [p·DATA_W +: DATA_W]
- rd_valid  out  NUM_PORTS  per-port data-valid strobe

## Operation
- States: IDLE, GEN, READY.
- IDLE or READY + start:
  - capture base/modulus; clear err and ready.
  - If base ≥ modulus: err=1 → IDLE.
  - Else: acc=0, cnt=0 → GEN.
- GEN, every cycle:
  - table[cnt] ← acc.
  - acc ← mod_add(acc, base).
  - cnt ← cnt+1.
  - After writing cnt = 2^IDX_W−1 → READY.
- start during GEN is ignored; the captured operands are unchanged.
- mod_add: s = acc + base, computed at DATA_W+1 bits. Result = s − modulus if s ≥ modulus, else s. The result is always < modulus; no other overflow handling is needed.
- Reads: in READY with rd_en[p]=1, rd_data[p] ← table[rd_idx[p]] and rd_valid[p] ← 1 on the next edge.
  - Otherwise rd_valid[p] ← 0 and rd_data[p] holds its last value.
  - Ports are fully independent. Any ports may read the same index in the same cycle.
- Reads issued in the same cycle as an accepted start return valid data from the old table; ready drops the following cycle.
- Table storage is not reset. Contents are undefined until the first completed generation.

## Timing
- Reset (rst_n=0 at an edge): state IDLE; busy=0, ready=0, err=0, rd_valid=0, rd_data=0, cnt=0, acc=0. Reset has priority over start and aborts GEN mid-run. ready stays 0 until a full regeneration completes.
- Start accepted at edge T: busy=1 from T+1.
- Entry j is written at edge T+1+j.
- busy=0 and ready=1 from T+2^IDX_W+1 (32 GEN cycles at default).
- err path: err=1 and busy=0 at T+1.
- Read latency: 1 cycle from rd_en to rd_valid/rd_data. Throughput is one read per port per cycle.
- The only combinational arithmetic path is mod_add, one DATA_W adder plus a comparator/subtractor per cycle. Registering it is not permitted, because it would break the one-entry-per-cycle schedule.

## Structure
- Shared package xpb_pkg:
  - state enum {IDLE, GEN, READY}
  - localparam helper DEPTH = 1<<IDX_W
  - packed-port slice helper functions
- Sub-module xpb_mod_add: parameter DATA_W; inputs a, b, m; output r = (a+b) mod m, assuming a, b < m. It is purely combinational and reused by later reduction blocks.
- Storage is a register array DEPTH × DATA_W with one write port and NUM_PORTS read ports.

## Test plan
- IDX_W=3, DATA_W=16, base=5, modulus=13, start → after 8 GEN cycles ready=1. Reads of indices 0..7 return 0,5,10,2,7,12,4,9 with 1-cycle latency.
- base=13, modulus=13 → err=1, busy=0 at T+1, ready=0. Reads give rd_valid=0. A subsequent valid start clears err.
- Reset asserted at GEN cycle 3 → all outputs 0 next edge and ready stays 0. Restart with base=3, modulus=7 → table 0,3,6,2,5,1,4,0.
- Both ports read index 6 in the same cycle, then port 0 reads idx 1 while port 1 is idle → rd_valid=2'b11 with both data=4, then 2'b01 with data=5.
- start pulsed during GEN with different operands → ignored, and the table matches the original operands. start in READY with new operands → the same-cycle read returns the old entry and ready drops at T+1.
- Default parameters (1024-bit) with random base < modulus → all 32 entries match the reference model (j·base) mod modulus.
